// File: rtl/alu_seq.sv
// alu_seq: sequential ALU feeding the accumulator register.
// Single-cycle logic/arith ops, multi-cycle shifts and shift-add multiply.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] res,
   output logic             res_we,
   output logic             z,
   output logic             c
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // counter must hold both a 3-bit shift count and WIDTH
   localparam int CLW = $clog2(WIDTH + 1);
   localparam int CW  = (CLW > 3) ? CLW : 3;
   localparam int PW  = 2 * WIDTH;

   logic [1:0]       state;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] mplr;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    prod;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] sh_val;
   logic             sh_out;
   logic [PW-1:0]    prod_nx;
   logic             is_shift;

   // status outputs decode only the state register
   assign busy   = (state != S_IDLE);
   assign res_we = (state == S_DONE);

   // single-cycle datapath on the live operands (only used in IDLE)
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         default: alu_res = '0;
      endcase
   end

   // one step of the multi-cycle shift and multiply engines
   always_comb begin
      is_shift = (op == OP_SHL) || (op == OP_SHR);
      if (op_r == OP_SHL) begin
         sh_val = {work[WIDTH-2:0], 1'b0};
         sh_out = work[WIDTH-1];
      end else begin
         sh_val = {1'b0, work[WIDTH-1:1]};
         sh_out = work[0];
      end
      prod_nx = prod + (mplr[0] ? mcand : '0);
   end

   // FSM, working registers and registered result/flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         op_r  <= '0;
         work  <= '0;
         mplr  <= '0;
         mcand <= '0;
         prod  <= '0;
         cnt   <= '0;
         res   <= '0;
         z     <= 1'b0;
         c     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_r <= op;
                  if (!is_shift && (op != OP_MUL)) begin
                     res   <= alu_res;
                     z     <= (alu_res == '0);
                     c     <= alu_c;
                     state <= S_DONE;
                  end else if (is_shift && (b[2:0] == 3'd0)) begin
                     res   <= a;
                     z     <= (a == '0);
                     c     <= 1'b0;
                     state <= S_DONE;
                  end else if (is_shift) begin
                     work  <= a;
                     cnt   <= CW'(b[2:0]);
                     state <= S_EXEC;
                  end else begin
                     mcand <= PW'(a);
                     mplr  <= b;
                     prod  <= '0;
                     cnt   <= CW'(WIDTH);
                     state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               cnt <= cnt - CW'(1);
               if (op_r == OP_MUL) begin
                  prod  <= prod_nx;
                  mcand <= {mcand[PW-2:0], 1'b0};
                  mplr  <= {1'b0, mplr[WIDTH-1:1]};
                  if (cnt == CW'(1)) begin
                     res   <= prod_nx[WIDTH-1:0];
                     z     <= (prod_nx[WIDTH-1:0] == '0);
                     c     <= |prod_nx[PW-1:WIDTH];
                     state <= S_DONE;
                  end
               end else begin
                  work <= sh_val;
                  if (cnt == CW'(1)) begin
                     res   <= sh_val;
                     z     <= (sh_val == '0);
                     c     <= sh_out;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq.
// Hand-computed vectors, latency/busy checks, handshake and abort cases.
module tb_alu_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic [7:0] res;
   logic       res_we;
   logic       z;
   logic       c;

   int total;
   int bad;

   alu_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .res   (res),
      .res_we(res_we),
      .z     (z),
      .c     (c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issue one op from IDLE and check latency, busy, result and flags
   task automatic run(input string tag, input logic [2:0] o,
                      input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] er, input logic ez,
                      input logic ec, input int elat);
      int lat;
      lat = 0;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = ia;
      b     = ib;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         chk({tag, ".busy"}, 16'(busy), 16'd1);
         if (res_we) begin
            lat = i;
            break;
         end
      end
      chk({tag, ".lat"}, 16'(lat), 16'(elat));
      chk({tag, ".res"}, 16'(res), 16'(er));
      chk({tag, ".z"}, 16'(z), 16'(ez));
      chk({tag, ".c"}, 16'(c), 16'(ec));
      @(negedge clk);
      chk({tag, ".we_off"}, 16'(res_we), 16'd0);
      chk({tag, ".busy_off"}, 16'(busy), 16'd0);
   endtask

   initial begin
      int n;
      logic [7:0] r;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a     = 8'd0;
      b     = 8'd0;

      repeat (2) @(negedge clk);
      chk("rst.busy", 16'(busy), 16'd0);
      chk("rst.we", 16'(res_we), 16'd0);
      chk("rst.res", 16'(res), 16'd0);
      chk("rst.z", 16'(z), 16'd0);
      chk("rst.c", 16'(c), 16'd0);
      rst = 1'b0;

      // leave nonzero state, then reset asynchronously mid-cycle
      run("sub_neg", 3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst.res", 16'(res), 16'd0);
      chk("arst.c", 16'(c), 16'd0);
      chk("arst.z", 16'(z), 16'd0);
      chk("arst.busy", 16'(busy), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      run("add", 3'b000, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1);
      run("add_wrap", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1);
      run("sub_eq", 3'b001, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1);
      run("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1);
      run("or", 3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1);
      run("xor", 3'b100, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1);
      run("shl3", 3'b101, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 4);
      run("shr1", 3'b110, 8'h81, 8'h01, 8'h40, 1'b0, 1'b1, 2);
      run("shl0", 3'b101, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1);
      run("shr7", 3'b110, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 8);
      run("mul", 3'b111, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 9);
      run("mul_ovf", 3'b111, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 9);

      // start pulse during a busy MUL must be ignored
      @(negedge clk);
      start = 1'b1;
      op    = 3'b111;
      a     = 8'h0F;
      b     = 8'h11;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      r = 8'h00;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (res_we) begin
            n++;
            r = res;
         end
         if (i == 3) begin
            start = 1'b1;
            op    = 3'b000;
            a     = 8'h01;
            b     = 8'h01;
         end
         if (i == 4) start = 1'b0;
      end
      chk("ign.count", 16'(n), 16'd1);
      chk("ign.res", 16'(r), 16'h00FF);

      // start held high: a pulse every second cycle
      @(negedge clk);
      start = 1'b1;
      op    = 3'b010;
      a     = 8'hF0;
      b     = 8'h3C;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("hold.we", 16'(res_we), 16'(i % 2));
         chk("hold.res", 16'(res), 16'h0030);
      end
      start = 1'b0;
      @(negedge clk);
      chk("hold.stop", 16'(res_we), 16'd0);

      // abort a MUL at cycle N+4
      @(negedge clk);
      start = 1'b1;
      op    = 3'b111;
      a     = 8'h0F;
      b     = 8'h11;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort.busy_pre", 16'(busy), 16'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort.we", 16'(res_we), 16'd0);
      chk("abort.busy", 16'(busy), 16'd0);
      chk("abort.res", 16'(res), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (res_we) n++;
      end
      chk("abort.nowe", 16'(n), 16'd0);
      run("post_abort", 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
